intf_rr_arb: RTL and testbench

Round-robin arbiter that shares a single `intf` interface instance, specifically its one-bit `val` signal, among NREQ requesters. It sits between several requesting sub-blocks inside a generate scope and the interface instance that a consumer module reads through its interface port. The block grants ownership for a burst, drives `val` from the owner's data bit, and inserts one turnaround cycle between owners. It also enforces a maximum burst length.

---
 rtl/intf_rr_arb_if.sv | 17 +
 rtl/intf_rr_arb.sv | 152 +++++++++++++++
 tb/tb_intf_rr_arb.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/intf_rr_arb_if.sv
`default_nettype none
// ============================================================================
//  Module   : intf
//  Purpose  : Shared single-bit bus interface. One producer (the round-robin
//             arbiter) drives val; consumers read it through the mon modport.
//  Ports    : val - shared data bit
//  Revision : 1.0 - initial release
// ============================================================================
interface intf #(
   parameter int PARAM = 1
) ();
   logic val;

   modport drv (output val);
   modport mon (input  val);
endinterface
`default_nettype wire

// File: rtl/intf_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : intf_rr_arb
//  Purpose  : Round-robin arbiter sharing intf.val among NREQ requesters.
//             Grants ownership for a burst (ended by last, a dropped request
//             or MAX_BURST beats), drives bus.val from the owner's data bit
//             and inserts one turnaround cycle between owners.
//  Ports    : clk   - clock, rising edge
//             rst   - synchronous active-high reset
//             req   - per-requester request level
//             dat   - per-requester data bit
//             last  - per-requester end-of-burst flag
//             gnt   - registered one-hot grant
//             busy  - bus owned (GRANT state)
//             tmo   - one-cycle pulse on forced (MAX_BURST) release
//             bus   - shared intf instance, val driven here only
//  Revision : 1.0 - initial release
// ============================================================================
module intf_rr_arb #(
   parameter int NREQ      = 4,
   parameter int MAX_BURST = 8,
   parameter int PARAM     = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] dat,
   input  logic [NREQ-1:0] last,
   output logic [NREQ-1:0] gnt,
   output logic            busy,
   output logic            tmo,
   intf.drv                bus
);

   localparam int         IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [7:0] C_MAX   = 8'(MAX_BURST);
   localparam logic [7:0] C_SAT   = 8'hFF;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
   localparam logic [1:0] S_TURN  = 2'd2;

   // Elaboration-time parameter checks
   if (PARAM == 0) begin : g_chk_param
      $error("intf_rr_arb: PARAM must be nonzero");
   end
   if (NREQ < 2 || NREQ > 8) begin : g_chk_nreq
      $error("intf_rr_arb: NREQ must be in 2..8");
   end
   if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_chk_burst
      $error("intf_rr_arb: MAX_BURST must be in 1..255");
   end

   logic [1:0]      r_state;
   logic [1:0]      w_next;
   logic [IW-1:0]   r_ptr;     // last winner; also the current owner in GRANT
   logic [7:0]      r_cnt;
   logic [NREQ-1:0] r_gnt;
   logic            r_tmo;

   logic            w_any;
   logic            w_found;
   logic [IW-1:0]   w_cand;
   logic [IW-1:0]   w_win;
   logic [NREQ-1:0] w_win_oh;
   logic            w_own_req;
   logic            w_own_last;
   logic            w_force;

   // Round-robin search starting just after the previous owner, so the
   // owner that was just released has the lowest priority.
   always_comb begin
      w_any   = |req;
      w_found = 1'b0;
      w_cand  = r_ptr;
      w_win   = r_ptr;
      for (int i = 1; i <= NREQ; i++) begin
         w_cand = IW'((int'(r_ptr) + i) % NREQ);
         if (!w_found && req[w_cand]) begin
            w_found = 1'b1;
            w_win   = w_cand;
         end
      end
      w_win_oh = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
   end

   assign w_own_req  = req[r_ptr];
   assign w_own_last = last[r_ptr];

   // Forced release only when the owner is still requesting and did not
   // flag last; a dropped request or last at the limit ends quietly.
   assign w_force = (r_state == S_GRANT) && w_own_req && !w_own_last &&
                    (r_cnt == C_MAX);

   // State register and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ptr   <= IW'(NREQ - 1);
         r_cnt   <= 8'd0;
         r_gnt   <= '0;
         r_tmo   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_tmo   <= w_force;
         if (w_next == S_GRANT && r_state != S_GRANT) begin
            r_gnt <= w_win_oh;
            r_ptr <= w_win;
            r_cnt <= 8'd1;
         end else if (w_next == S_GRANT) begin
            if (r_cnt != C_SAT) begin
               r_cnt <= r_cnt + 8'd1;
            end
         end else begin
            r_gnt <= '0;
         end
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_next = S_GRANT;
            end
         end
         S_GRANT: begin
            if (!w_own_req || w_own_last || (r_cnt == C_MAX)) begin
               w_next = S_TURN;
            end
         end
         S_TURN: begin
            w_next = w_any ? S_GRANT : S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Outputs; bus.val follows the owner's data bit combinationally.
   always_comb begin
      busy    = (r_state == S_GRANT);
      gnt     = r_gnt;
      tmo     = r_tmo;
      bus.val = (r_state == S_GRANT) ? dat[r_ptr] : 1'b0;
   end

endmodule
`default_nettype wire

// File: tb/tb_intf_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_intf_rr_arb
//  Purpose  : Directed self-checking bench for intf_rr_arb (NREQ=4,
//             MAX_BURST=8). Inputs change just after a rising edge; outputs
//             are checked 1 ns later, before the next edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_intf_rr_arb;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] dat;
   logic [3:0] last;
   logic [3:0] gnt;
   logic       busy;
   logic       tmo;
   logic [3:0] e;

   int n_assert = 0;
   int n_fail   = 0;

   intf #(.PARAM(1)) bus_if ();

   intf_rr_arb #(
      .NREQ      (4),
      .MAX_BURST (8),
      .PARAM     (1)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .dat  (dat),
      .last (last),
      .gnt  (gnt),
      .busy (busy),
      .tmo  (tmo),
      .bus  (bus_if)
   );

   always #5 clk = ~clk;

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic [3:0] r, input logic [3:0] d, input logic [3:0] l);
      req  = r;
      dat  = d;
      last = l;
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [3:0] g, input logic b,
                          input logic t, input logic v);
      chk({tag, ".gnt"},  {4'b0000, gnt},        {4'b0000, g});
      chk({tag, ".busy"}, {7'b0000000, busy},    {7'b0000000, b});
      chk({tag, ".tmo"},  {7'b0000000, tmo},     {7'b0000000, t});
      chk({tag, ".val"},  {7'b0000000, bus_if.val}, {7'b0000000, v});
   endtask

   initial begin
      rst  = 1'b1;
      req  = 4'b1111;
      dat  = 4'b0000;
      last = 4'b0000;

      // Reset held three cycles with all requesting
      adv(); adv(); adv();
      drv(4'b1111, 4'b1111, 4'b0000);
      chk_out("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      adv();

      // Round-robin, 2-beat bursts: owners 0,1,2,3,0
      for (int o = 0; o < 5; o++) begin
         e = 4'b0001 << (o % 4);
         drv(4'b1111, 4'b0000, 4'b0000);
         chk_out("rr_beat1", e, 1'b1, 1'b0, 1'b0);
         adv();
         drv(4'b1111, 4'b0000, e);
         chk_out("rr_beat2", e, 1'b1, 1'b0, 1'b0);
         adv();
         drv((o == 4) ? 4'b0100 : 4'b1111, 4'b0000, 4'b0000);
         chk_out("rr_turn", 4'b0000, 1'b0, 1'b0, 1'b0);
         adv();
      end

      // Data path: owner 2, dat[2] = 1,0,1, last on beat 3
      drv(4'b0100, 4'b1111, 4'b0000);
      chk_out("dp_beat1", 4'b0100, 1'b1, 1'b0, 1'b1);
      adv();
      drv(4'b0100, 4'b1011, 4'b1011);   // non-owner dat/last toggled
      chk_out("dp_beat2", 4'b0100, 1'b1, 1'b0, 1'b0);
      adv();
      drv(4'b0100, 4'b0100, 4'b0100);
      chk_out("dp_beat3", 4'b0100, 1'b1, 1'b0, 1'b1);
      adv();
      drv(4'b0010, 4'b1111, 4'b0000);
      chk_out("dp_turn", 4'b0000, 1'b0, 1'b0, 1'b0);
      adv();

      // Timeout: owner 1 never asserts last -> 8 beats then tmo
      for (int b = 1; b <= 8; b++) begin
         drv(4'b0010, 4'b0000, 4'b0000);
         chk_out("tmo_beat", 4'b0010, 1'b1, 1'b0, 1'b0);
         adv();
      end
      drv(4'b0010, 4'b0000, 4'b0000);
      chk_out("tmo_turn", 4'b0000, 1'b0, 1'b1, 1'b0);
      adv();

      // Same owner, last on beat 8 -> no tmo
      for (int b = 1; b <= 8; b++) begin
         drv(4'b0010, 4'b0000, (b == 8) ? 4'b0010 : 4'b0000);
         chk_out("last8_beat", 4'b0010, 1'b1, 1'b0, 1'b0);
         adv();
      end
      drv(4'b1000, 4'b0000, 4'b0000);
      chk_out("last8_turn", 4'b0000, 1'b0, 1'b0, 1'b0);
      adv();

      // Request drop: owner 3 drops req on beat 2
      drv(4'b1000, 4'b0000, 4'b0000);
      chk_out("drop_beat1", 4'b1000, 1'b1, 1'b0, 1'b0);
      adv();
      drv(4'b0111, 4'b0000, 4'b0000);
      chk_out("drop_beat2", 4'b1000, 1'b1, 1'b0, 1'b0);
      adv();
      drv(4'b1111, 4'b0000, 4'b0000);
      chk_out("drop_turn", 4'b0000, 1'b0, 1'b0, 1'b0);
      adv();

      // Owner 0 wins after 3 (ptr = 3); reset during its beat 4
      for (int b = 1; b <= 4; b++) begin
         drv(4'b1111, 4'b1111, 4'b0000);
         chk_out("mid_beat", 4'b0001, 1'b1, 1'b0, 1'b1);
         if (b == 4) begin
            rst = 1'b1;
         end
         adv();
      end
      drv(4'b1111, 4'b1111, 4'b0000);
      chk_out("mid_reset", 4'b0000, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      adv();
      drv(4'b1111, 4'b0000, 4'b0000);
      chk_out("post_reset", 4'b0001, 1'b1, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
